// File: rtl/mem_bus_interface_if.sv
// rtl/mem_bus_interface_if.sv - CPU request / Avalon-MM master signal bundle (MEM_ALIGN_CHECK_EN adds misalign_err)
interface mem_bus_interface_if;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        mem_stall;
  logic        mem_done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  // Bridge side: takes CPU requests and drives the Avalon-MM bus
  modport master (
    input  req_read, req_write, req_size, req_addr, req_wdata,
    input  avm_readdata, avm_waitrequest,
`ifdef MEM_ALIGN_CHECK_EN
    output misalign_err,
`endif
    output rdata, mem_stall, mem_done,
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );

  // Environment side: CPU requester plus Avalon-MM slave
  modport slave (
    output req_read, req_write, req_size, req_addr, req_wdata,
    output avm_readdata, avm_waitrequest,
`ifdef MEM_ALIGN_CHECK_EN
    input  misalign_err,
`endif
    input  rdata, mem_stall, mem_done,
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );
endinterface

// File: rtl/mem_bus_interface.sv
// rtl/mem_bus_interface.sv - CPU load/store to Avalon-MM master bridge (optional MEM_ALIGN_CHECK_EN misalignment trap)
module mem_bus_interface (
  input logic               clk,
  input logic               reset,
  mem_bus_interface_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic [31:0] address_q;
  logic        read_q;
  logic        write_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        req_any;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rd_byte;
  logic [31:0] rd_half;
  logic [31:0] rd_sel;

  assign req_any = bus.req_read | bus.req_write;

  // Lane enables and lane-replicated store data for the incoming request; size 11 behaves as word
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be_next    = 4'b0001 << bus.req_addr[1:0];
        wdata_next = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = bus.req_wdata;
      end
    endcase
  end

  // Right-justify and zero-extend the returned word for the latched size/offset
  assign rd_byte = bus.avm_readdata >> {off_q, 3'b000};
  assign rd_half = bus.avm_readdata >> {off_q[1], 4'b0000};
  always_comb begin
    rd_sel = bus.avm_readdata;
    case (size_q)
      2'b00:   rd_sel = {24'h0, rd_byte[7:0]};
      2'b01:   rd_sel = {16'h0, rd_half[15:0]};
      default: rd_sel = bus.avm_readdata;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  logic err_q;
  assign misaligned = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                      (bus.req_size[1] & (|bus.req_addr[1:0]));
  assign bus.misalign_err = err_q;
`endif

  // Request FSM: latch in IDLE, hold the bus in ACCESS until waitrequest drops, pulse done in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      rdata_q   <= 32'h0;
      done_q    <= 1'b0;
      address_q <= 32'h0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_any) begin
            size_q <= bus.req_size;
            off_q  <= bus.req_addr[1:0];
`ifdef MEM_ALIGN_CHECK_EN
            if (misaligned) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else
`endif
            begin
              state     <= ACCESS;
              read_q    <= ~bus.req_write;
              write_q   <= bus.req_write;
              address_q <= {bus.req_addr[31:2], 2'b00};
              be_q      <= be_next;
              wdata_q   <= wdata_next;
            end
          end
        end
        ACCESS: begin
          if (!bus.avm_waitrequest) begin
            if (read_q) rdata_q <= rd_sel;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall covers the request cycle itself so the CPU never runs past an unaccepted access
  assign bus.mem_stall = (state == ACCESS) | ((state == IDLE) & req_any & ~reset);

  assign bus.rdata          = rdata_q;
  assign bus.mem_done       = done_q;
  assign bus.avm_address    = address_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_byteenable = be_q;
  assign bus.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
// tb/tb_mem_bus_interface.sv - directed self-checking bench for mem_bus_interface (MEM_ALIGN_CHECK_EN aware)
module tb_mem_bus_interface;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_bus_interface_if bus ();

  mem_bus_interface dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic rd, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic drop_request();
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
  endtask

  // Zero-wait read: request at N0, bus cycle at N1, done at N2
  task automatic zero_wait_read(input string tag, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] rdword, input logic [3:0] exp_be,
                                input logic [31:0] exp_rdata);
    @(negedge clk);
    request(1'b1, 1'b0, size, addr, 32'h0);
    bus.avm_readdata    = rdword;
    bus.avm_waitrequest = 1'b0;
    #1 check({tag, "_stall_req"}, {31'h0, bus.mem_stall}, 32'h1);
    @(negedge clk);
    check({tag, "_avm_read"}, {31'h0, bus.avm_read}, 32'h1);
    check({tag, "_avm_write"}, {31'h0, bus.avm_write}, 32'h0);
    check({tag, "_address"}, bus.avm_address, {addr[31:2], 2'b00});
    check({tag, "_be"}, {28'h0, bus.avm_byteenable}, {28'h0, exp_be});
    check({tag, "_done_early"}, {31'h0, bus.mem_done}, 32'h0);
    drop_request();
    @(negedge clk);
    check({tag, "_done"}, {31'h0, bus.mem_done}, 32'h1);
    check({tag, "_rdata"}, bus.rdata, exp_rdata);
    check({tag, "_read_off"}, {31'h0, bus.avm_read}, 32'h0);
    check({tag, "_stall_done"}, {31'h0, bus.mem_stall}, 32'h0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'h0, bus.mem_done}, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    request(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    bus.avm_readdata    = 32'h0;
    bus.avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_stall", {31'h0, bus.mem_stall}, 32'h0);
    check("rst_done", {31'h0, bus.mem_done}, 32'h0);
    check("rst_read", {31'h0, bus.avm_read}, 32'h0);
    check("rst_write", {31'h0, bus.avm_write}, 32'h0);
    check("rst_be", {28'h0, bus.avm_byteenable}, 32'h0);
    check("rst_addr", bus.avm_address, 32'h0);
    check("rst_wdata", bus.avm_writedata, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    check("rst_err", {31'h0, bus.misalign_err}, 32'h0);
`endif
    reset = 1'b0;

    // Word, byte and half reads
    zero_wait_read("rd_word", 2'b10, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    zero_wait_read("rd_byte3", 2'b00, 32'h0000_1003, 32'h80AA_BBCC, 4'b1000, 32'h0000_0080);
    zero_wait_read("rd_byte1", 2'b00, 32'h0000_1001, 32'h1234_5678, 4'b0010, 32'h0000_0056);
    zero_wait_read("rd_half_hi", 2'b01, 32'h0000_2002, 32'h1234_5678, 4'b1100, 32'h0000_1234);
    zero_wait_read("rd_half_lo", 2'b01, 32'h0000_3000, 32'h89AB_CDEF, 4'b0011, 32'h0000_CDEF);
    zero_wait_read("rd_size3", 2'b11, 32'h0000_3004, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    // Half write with three waitrequest cycles; rdata must keep the last read value
    @(negedge clk);
    request(1'b0, 1'b1, 2'b01, 32'h0000_2002, 32'h1234_ABCD);
    bus.avm_waitrequest = 1'b1;
    #1 check("wr_stall_req", {31'h0, bus.mem_stall}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("wr_write", {31'h0, bus.avm_write}, 32'h1);
      check("wr_read", {31'h0, bus.avm_read}, 32'h0);
      check("wr_wdata", bus.avm_writedata, 32'hABCD_ABCD);
      check("wr_be", {28'h0, bus.avm_byteenable}, 32'hC);
      check("wr_addr", bus.avm_address, 32'h0000_2000);
      check("wr_stall", {31'h0, bus.mem_stall}, 32'h1);
      check("wr_no_done", {31'h0, bus.mem_done}, 32'h0);
      drop_request();
      if (i == 4) bus.avm_waitrequest = 1'b0;
    end
    @(negedge clk);
    check("wr_done", {31'h0, bus.mem_done}, 32'h1);
    check("wr_write_off", {31'h0, bus.avm_write}, 32'h0);
    check("wr_stall_done", {31'h0, bus.mem_stall}, 32'h0);
    check("wr_rdata_kept", bus.rdata, 32'h0BAD_F00D);
    @(negedge clk);

    // Byte write replicates the low byte into every lane
    request(1'b0, 1'b1, 2'b00, 32'h0000_0041, 32'hFFFF_FF5A);
    @(negedge clk);
    check("wrb_wdata", bus.avm_writedata, 32'h5A5A_5A5A);
    check("wrb_be", {28'h0, bus.avm_byteenable}, 32'h2);
    drop_request();
    @(negedge clk);
    check("wrb_done", {31'h0, bus.mem_done}, 32'h1);
    @(negedge clk);

    // Read and write together: write wins, rdata unchanged
    request(1'b1, 1'b1, 2'b10, 32'h0000_0040, 32'h0000_0055);
    bus.avm_readdata = 32'h1111_1111;
    @(negedge clk);
    check("both_write", {31'h0, bus.avm_write}, 32'h1);
    check("both_read", {31'h0, bus.avm_read}, 32'h0);
    check("both_addr", bus.avm_address, 32'h0000_0040);
    check("both_wdata", bus.avm_writedata, 32'h0000_0055);
    drop_request();
    @(negedge clk);
    check("both_done", {31'h0, bus.mem_done}, 32'h1);
    check("both_rdata", bus.rdata, 32'h0BAD_F00D);
    @(negedge clk);

    // Misaligned word read at 0x1002
`ifdef MEM_ALIGN_CHECK_EN
    request(1'b1, 1'b0, 2'b10, 32'h0000_1002, 32'h0);
    bus.avm_readdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("mis_done", {31'h0, bus.mem_done}, 32'h1);
    check("mis_err", {31'h0, bus.misalign_err}, 32'h1);
    check("mis_no_read", {31'h0, bus.avm_read}, 32'h0);
    check("mis_rdata", bus.rdata, 32'h0BAD_F00D);
    drop_request();
    @(negedge clk);
    check("mis_err_pulse", {31'h0, bus.misalign_err}, 32'h0);
    check("mis_done_pulse", {31'h0, bus.mem_done}, 32'h0);
`else
    zero_wait_read("mis_word", 2'b10, 32'h0000_1002, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    zero_wait_read("mis_half", 2'b01, 32'h0000_1001, 32'hCAFE_F00D, 4'b0011, 32'h0000_F00D);
`endif

    // Reset on the second ACCESS cycle, with a new request held through reset
    @(negedge clk);
    request(1'b1, 1'b0, 2'b10, 32'h0000_0500, 32'h0);
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    check("rsta_read1", {31'h0, bus.avm_read}, 32'h1);
    @(negedge clk);
    check("rsta_read2", {31'h0, bus.avm_read}, 32'h1);
    reset = 1'b1;
    request(1'b1, 1'b0, 2'b10, 32'h0000_0600, 32'h0);
    @(negedge clk);
    check("rsta_read_off", {31'h0, bus.avm_read}, 32'h0);
    check("rsta_no_done", {31'h0, bus.mem_done}, 32'h0);
    check("rsta_stall", {31'h0, bus.mem_stall}, 32'h0);
    check("rsta_rdata", bus.rdata, 32'h0);
    reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = 32'h7654_3210;
    @(negedge clk);
    check("rsta_resample", {31'h0, bus.avm_read}, 32'h1);
    check("rsta_addr", bus.avm_address, 32'h0000_0600);
    check("rsta_done_none", {31'h0, bus.mem_done}, 32'h0);
    drop_request();
    @(negedge clk);
    check("rsta_done", {31'h0, bus.mem_done}, 32'h1);
    check("rsta_rdata_new", bus.rdata, 32'h7654_3210);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_interface.md
MEM_BUS_INTERFACE -- requirements
Module: mem_bus_interface

Interface
REQ-001 The block SHALL have port clk, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-002 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-003 The block SHALL have port req_read, input, 1: the CPU requests a load.
REQ-004 The block SHALL have port req_write, input, 1: the CPU requests a store.
REQ-005 The block SHALL have port req_size, input, 2: access size, 00 byte, 01 half, 10 word, 11 treated as word.
REQ-006 The block SHALL have port req_addr, input, 32: byte address from the datapath memloc.
REQ-007 The block SHALL have port req_wdata, input, 32: store data, LSB-aligned, from the datapath writedata.
REQ-008 The block SHALL have port rdata, output, 32: load data, LSB-aligned and zero-filled above the access size, feeding the datapath ReadData.
REQ-009 The block SHALL have port mem_stall, output, 1: holds the CPU while an access is in progress.
REQ-010 The block SHALL have port mem_done, output, 1: a one-cycle completion pulse.
REQ-011 The block SHALL have ports avm_address (output, 32), avm_read (output, 1), avm_write (output, 1), avm_byteenable (output, 4), avm_writedata (output, 32), avm_readdata (input, 32) and avm_waitrequest (input, 1), forming the Avalon-MM master.
REQ-012 The block SHALL have port misalign_err, output, 1, present only when MEM_ALIGN_CHECK_EN is defined.

Function
REQ-013 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-014 Requests SHALL be sampled only in IDLE; requests presented in ACCESS or DONE SHALL be ignored.
REQ-015 In IDLE, when req_read or req_write is high, the FSM SHALL latch address, size, data and direction and go to ACCESS.
REQ-016 When req_read and req_write are both high, the write SHALL win.
REQ-017 In ACCESS, avm_read or avm_write SHALL be held high, with all avm_* outputs stable, until a cycle where avm_waitrequest is 0; at that edge the FSM SHALL go to DONE.
REQ-018 On a read, avm_readdata SHALL be captured at the completing edge of REQ-017.
REQ-019 In DONE, mem_done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-020 The requester SHALL deassert its request before the edge that ends DONE.
REQ-021 mem_stall SHALL equal (state==ACCESS) OR (state==IDLE AND (req_read OR req_write)); it SHALL be 0 in DONE.
REQ-022 Minimum access latency SHALL be 2 cycles from the request in IDLE to mem_done, plus one cycle per cycle of avm_waitrequest high.
REQ-023 avm_address SHALL be {addr[31:2], 2'b00}.
REQ-024 avm_byteenable SHALL be 4'b0001 shifted left by addr[1:0] for a byte access, 0011 or 1100 selected by addr[1] for a half access, and 1111 for a word access.
REQ-025 avm_writedata SHALL replicate wdata[7:0] into all 4 lanes for a byte access, replicate wdata[15:0] into both halves for a half access, and pass wdata through for a word access.
REQ-026 rdata SHALL be the captured readdata shifted right by 8*addr[1:0] for a byte access or 16*addr[1] for a half access, with the upper bits zeroed.
REQ-027 rdata SHALL hold its value until the next read completes; writes SHALL not alter rdata.
REQ-028 Without MEM_ALIGN_CHECK_EN, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) SHALL ignore the offending low address bits.

Reset
REQ-029 While reset is high at an edge, the state SHALL become IDLE and all outputs (rdata, mem_stall, mem_done, avm_*, misalign_err) SHALL become 0 at that edge.
REQ-030 A reset asserted during ACCESS SHALL abandon the bus transaction: avm_read and avm_write SHALL be 0 from the following cycle, and no mem_done SHALL be produced.
REQ-031 A request held high during reset SHALL be sampled in the first IDLE cycle after reset deasserts.

Configuration
REQ-032 The macro MEM_ALIGN_CHECK_EN SHALL control misalignment checking.
REQ-033 When MEM_ALIGN_CHECK_EN is defined, a misaligned request SHALL go from IDLE directly to DONE with no avm_read or avm_write asserted, misalign_err SHALL be 1 during that DONE cycle only, and rdata SHALL be unchanged.
REQ-034 When MEM_ALIGN_CHECK_EN is undefined, the misalign_err port and its logic SHALL be absent and REQ-028 SHALL apply.

Verification
REQ-035 Word read, addr 0x1000, waitrequest 0, readdata 0xDEADBEEF -> avm_read high 1 cycle, byteenable 1111, mem_done at cycle 2, rdata 0xDEADBEEF.
REQ-036 Byte read, addr 0x1003, readdata 0x80AABBCC -> avm_address 0x1000, byteenable 1000, rdata 0x00000080.
REQ-037 Half write, addr 0x2002, wdata 0x1234ABCD, waitrequest high 3 cycles -> avm_writedata 0xABCDABCD, byteenable 1100, stable for 4 cycles, mem_stall high 4 cycles, mem_done on the 5th.
REQ-038 Simultaneous req_read and req_write at addr 0x40 -> only avm_write asserted; rdata unchanged.
REQ-039 Reset asserted on the second ACCESS cycle with waitrequest high -> avm_read 0 the next cycle, no mem_done, state IDLE.
REQ-040 With MEM_ALIGN_CHECK_EN defined, word read at addr 0x1002 -> no avm_read, mem_done and misalign_err high on cycle 2; without the macro, the same request reads address 0x1000.
